// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter.
//   - RAM write-size encodings (shared by d_wsize and ram_we)
//   - FSM state and transaction-owner encodings
//   - helpers that classify a write-size code
package mem_arbiter_pkg;

    localparam logic [2:0] SZ_NONE = 3'b000;
    localparam logic [2:0] SZ_B    = 3'b100;
    localparam logic [2:0] SZ_H    = 3'b010;
    localparam logic [2:0] SZ_W    = 3'b001;

    // Wide enough for the largest allowed MAX_D_STREAK (15).
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    function automatic logic is_write_size(input logic [2:0] sz);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W);
    endfunction

    function automatic logic is_legal_size(input logic [2:0] sz);
        return (sz == SZ_NONE) || is_write_size(sz);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requesters.
// Ports:
//   if_req, d_req : pending requests
//   streak        : consecutive data grants issued while fetch was waiting
//   grant_i       : fetch would win this cycle
//   grant_d       : data would win this cycle
// At most one grant is ever high. Data is preferred until the streak
// reaches MAX_D_STREAK, at which point a waiting fetch gets its turn.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_i,
    output logic                grant_d
);

    logic fetch_starved;

    assign fetch_starved = if_req && (streak == STREAK_W'(MAX_D_STREAK));
    assign grant_d       = d_req && !fetch_starved;
    assign grant_i       = if_req && !grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one synchronous RAM between instruction fetch and
// load/store. Each transaction takes an ISSUE cycle (RAM inputs driven)
// and a RESP cycle (RAM read data returned, owner's valid pulses).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req/if_addr/if_ready          : fetch request handshake
//   if_valid/if_data                 : fetch response
//   d_req/d_addr/d_wsize/d_wdata     : data request (d_wsize 000 = read)
//   d_ready                          : data request accepted
//   d_valid/d_rdata/d_err            : data response, d_err for bad size
//   ram_addr/ram_we/ram_wdata        : registered RAM inputs
//   ram_rdata                        : RAM read data, 1-cycle latency
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [31:0]       if_data,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_wsize,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [2:0]        ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_e              state_q, state_d;
    owner_e              owner_q;
    logic [2:0]          wsize_q;
    logic [STREAK_W-1:0] streak_q;
    logic [31:0]         if_data_q, d_rdata_q;

    logic grant_i, grant_d;
    logic can_accept, accept;
    logic resp_i, resp_d;

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_pick (
        .if_req  (if_req),
        .d_req   (d_req),
        .streak  (streak_q),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    // Accepting in RESP overlaps the next ISSUE with the current response,
    // giving one transaction every two cycles with no IDLE gap.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign if_ready   = can_accept && grant_i;
    assign d_ready    = can_accept && grant_d;
    assign accept     = if_ready || d_ready;

    assign resp_i = (state_q == ST_RESP) && (owner_q == OWN_I);
    assign resp_d = (state_q == ST_RESP) && (owner_q == OWN_D);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = accept ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // RAM read data only exists during RESP, so the response data is a
    // bypass of ram_rdata in that cycle and a held copy otherwise.
    always_comb begin
        if_valid = resp_i;
        if_data  = if_data_q;
        d_valid  = resp_d;
        d_err    = 1'b0;
        d_rdata  = d_rdata_q;
        if (resp_i) begin
            if_data = ram_rdata;
        end
        if (resp_d) begin
            d_err   = !is_legal_size(wsize_q);
            d_rdata = (wsize_q == SZ_NONE) ? ram_rdata : 32'h0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_I;
            wsize_q   <= SZ_NONE;
            streak_q  <= '0;
            ram_addr  <= '0;
            ram_we    <= SZ_NONE;
            ram_wdata <= '0;
            if_data_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            // Write strobe only ever lives for the single ISSUE cycle.
            ram_we  <= SZ_NONE;

            // The RAM input registers double as the latched request fields,
            // so they already hold the request during ISSUE.
            if (accept) begin
                owner_q   <= d_ready ? OWN_D : OWN_I;
                wsize_q   <= d_ready ? d_wsize : SZ_NONE;
                ram_addr  <= d_ready ? d_addr : if_addr;
                ram_wdata <= d_ready ? d_wdata : 32'h0;
                ram_we    <= (d_ready && is_write_size(d_wsize)) ? d_wsize : SZ_NONE;
            end

            if (d_ready) begin
                if (!if_req) begin
                    streak_q <= '0;
                end else if (streak_q != STREAK_W'(MAX_D_STREAK)) begin
                    streak_q <= streak_q + 1'b1;
                end
            end else if (if_ready) begin
                streak_q <= '0;
            end

            if (resp_i) if_data_q <= if_data;
            if (resp_d) d_rdata_q <= d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push the expected response
// (data, error flag, cycle) when a request is accepted; a monitor pops and
// compares whenever a valid pulse appears.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready, if_valid;
    logic [31:0]       if_data;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [2:0]        d_wsize;
    logic [31:0]       d_wdata;
    logic              d_ready, d_valid, d_err;
    logic [31:0]       d_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [2:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_valid(if_valid), .if_data(if_data),
        .d_req(d_req), .d_addr(d_addr), .d_wsize(d_wsize), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: registered read, sub-word writes hit low lanes.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr[5:0]];
        case (ram_we)
            SZ_W:    mem[ram_addr[5:0]]        <= ram_wdata;
            SZ_H:    mem[ram_addr[5:0]][15:0]  <= ram_wdata[15:0];
            SZ_B:    mem[ram_addr[5:0]][7:0]   <= ram_wdata[7:0];
            default: ;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q_if[$];
    exp_t q_d[$];
    byte  grants[$];
    bit   log_grants = 1'b0;
    int   we_cycles  = 0;
    logic [2:0] last_we = SZ_NONE;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    exp_t em_i, em_d;
    always @(negedge clk) begin
        if (!rst) begin
            if (if_ready || d_ready) check("ready_exclusive", {31'b0, if_ready && d_ready}, 32'h0);
            if (ram_we != SZ_NONE) begin
                we_cycles++;
                last_we = ram_we;
            end
            if (log_grants && if_ready) grants.push_back(8'h49);
            if (log_grants && d_ready)  grants.push_back(8'h44);
            if (if_valid) begin
                if (q_if.size() == 0) begin
                    check("if_valid_unexpected", 32'h1, 32'h0);
                end else begin
                    em_i = q_if.pop_front();
                    check("if_data", if_data, em_i.data);
                    check("if_latency", cyc, em_i.cyc);
                end
            end
            if (d_valid) begin
                if (q_d.size() == 0) begin
                    check("d_valid_unexpected", 32'h1, 32'h0);
                end else begin
                    em_d = q_d.pop_front();
                    check("d_rdata", d_rdata, em_d.data);
                    check("d_err", {31'b0, d_err}, {31'b0, em_d.err});
                    check("d_latency", cyc, em_d.cyc);
                end
            end
        end
    end

    // Drivers: called just after a rising edge; return just after the rising
    // edge that ends the accept cycle (i.e. inside the ISSUE cycle).
    task automatic d_op(input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input bit hold,
                        output int acc);
        int   n;
        exp_t e;
        d_req = 1'b1; d_addr = addr; d_wsize = sz; d_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!d_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!d_ready) begin
            check("d_accept_timeout", 32'h0, 32'h1);
            d_req = 1'b0;
            return;
        end
        e.data = exp_rd; e.err = exp_err; e.cyc = cyc + 2;
        q_d.push_back(e);
        @(posedge clk); #1;
        if (!hold) d_req = 1'b0;
        check("d_ram_addr", ram_addr, addr);
        check("d_ram_wdata", ram_wdata, wdata);
    endtask

    task automatic f_op(input logic [31:0] addr, input logic [31:0] exp_rd, input bit hold);
        int   n;
        exp_t e;
        if_req = 1'b1; if_addr = addr;
        n = 0;
        @(negedge clk);
        while (!if_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!if_ready) begin
            check("if_accept_timeout", 32'h0, 32'h1);
            if_req = 1'b0;
            return;
        end
        e.data = exp_rd; e.err = 1'b0; e.cyc = cyc + 2;
        q_if.push_back(e);
        @(posedge clk); #1;
        if (!hold) if_req = 1'b0;
        check("if_ram_addr", ram_addr, addr);
        check("if_ram_we", {29'b0, ram_we}, {29'b0, SZ_NONE});
    endtask

    task automatic drain();
        int n = 0;
        while ((q_if.size() != 0 || q_d.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q_if.size() + q_d.size(), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        int    a0, a1, a2, we0, dummy, n;
        string exp_order;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[5] = 32'h00A00093;
        mem[6] = 32'h12345678;

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_addr = '0; d_wsize = SZ_NONE; d_wdata = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_d_valid", {31'b0, d_valid}, 32'h0);
        check("rst_d_err", {31'b0, d_err}, 32'h0);
        check("rst_ram_we", {29'b0, ram_we}, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fetch only
        f_op(32'd5, 32'h00A00093, 1'b0);
        drain();

        // Word write then read back
        we0 = we_cycles;
        d_op(32'd8, SZ_W, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, dummy);
        drain();
        check("word_we_cycles", we_cycles - we0, 32'd1);
        check("word_we_size", {29'b0, last_we}, {29'b0, SZ_W});
        d_op(32'd8, SZ_NONE, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, dummy);
        drain();

        // Half and byte writes into low lanes
        d_op(32'd10, SZ_W, 32'hAAAAAAAA, 32'h0, 1'b0, 1'b0, dummy);
        d_op(32'd10, SZ_H, 32'h00001234, 32'h0, 1'b0, 1'b0, dummy);
        drain();
        check("half_we_size", {29'b0, last_we}, {29'b0, SZ_H});
        d_op(32'd10, SZ_B, 32'h000000EE, 32'h0, 1'b0, 1'b0, dummy);
        drain();
        check("byte_we_size", {29'b0, last_we}, {29'b0, SZ_B});
        d_op(32'd10, SZ_NONE, 32'h0, 32'hAAAA12EE, 1'b0, 1'b0, dummy);
        drain();

        // Illegal size: no write, error response with zero data
        we0 = we_cycles;
        d_op(32'd8, 3'b011, 32'h55555555, 32'h0, 1'b1, 1'b0, dummy);
        drain();
        check("illegal_we_cycles", we_cycles - we0, 32'd0);
        d_op(32'd8, SZ_NONE, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, dummy);
        drain();

        // Back-to-back reads with d_req held
        d_op(32'd8, SZ_NONE, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, a0);
        d_op(32'd5, SZ_NONE, 32'h0, 32'h00A00093, 1'b0, 1'b1, a1);
        d_op(32'd6, SZ_NONE, 32'h0, 32'h12345678, 1'b0, 1'b0, a2);
        check("b2b_gap_1", a1 - a0, 32'd2);
        check("b2b_gap_2", a2 - a1, 32'd2);
        drain();

        // Contention: both requesters held high
        grants.delete();
        log_grants = 1'b1;
        fork
            begin
                f_op(32'd5, 32'h00A00093, 1'b1);
                f_op(32'd6, 32'h12345678, 1'b0);
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    int acc;
                    d_op(32'd8, SZ_NONE, 32'h0, 32'hDEADBEEF, 1'b0, (i < 7), acc);
                end
            end
        join
        log_grants = 1'b0;
        drain();
        exp_order = "DDDDIDDDDI";
        check("grant_count", grants.size(), exp_order.len());
        for (int i = 0; i < exp_order.len() && i < grants.size(); i++)
            check($sformatf("grant_order_%0d", i), {24'b0, grants[i]}, {24'b0, exp_order[i]});

        // Reset in the ISSUE cycle of a write
        d_req = 1'b1; d_addr = 32'd12; d_wsize = SZ_W; d_wdata = 32'h77777777;
        n = 0;
        @(negedge clk);
        while (!d_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstop_accept", {31'b0, d_ready}, 32'h1);
        @(posedge clk); #1;
        d_req = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("rstop_issue_we", {29'b0, ram_we}, {29'b0, SZ_W});
        @(negedge clk);
        check("rstop_we_cleared", {29'b0, ram_we}, 32'h0);
        check("rstop_no_valid", {31'b0, d_valid}, 32'h0);
        check("rstop_ram_addr", ram_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstop_idle_no_valid", {31'b0, d_valid}, 32'h0);
        @(posedge clk); #1;
        f_op(32'd6, 32'h12345678, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
